// File: rtl/hc595_ctrl.sv
// Serial frame transmitter for two cascaded 74HC595s: shifts {sel, seg} out on DS/SHCP,
// latches each frame with one STCP pulse and enables outputs after the first latch.
module hc595_ctrl #(
  parameter int unsigned CNT_DIV    = 4,
  parameter int unsigned FRAME_BITS = 14
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] sel,
  input  logic [7:0] seg,
  input  logic       shift_en,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe,
  output logic       frame_done
);

  localparam int unsigned CntW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [CntW-1:0] ClkLast = CntW'(CNT_DIV - 1);
  localparam logic [CntW-1:0] ClkHalf = CntW'(CNT_DIV / 2);
  localparam logic [3:0]      BitLast = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StLatch} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_clk_q;
  logic [3:0]      cnt_bit_q;
  logic [13:0]     frame_q;
  logic [CntW-1:0] clk_inc;
  logic [3:0]      bit_inc;

  assign clk_inc = cnt_clk_q + CntW'(1);
  assign bit_inc = cnt_bit_q + 4'd1;

  // Slots 0..7 carry seg LSB first, slots 8..13 carry sel MSB first.
  function automatic logic slot_bit(input logic [13:0] f, input logic [3:0] k);
    logic [3:0] idx;
    idx = (k < 4'd8) ? k : (4'd13 - (k - 4'd8));
    return f[idx];
  endfunction

  // Outputs are registered alongside the state so they line up with the state they describe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      cnt_clk_q  <= '0;
      cnt_bit_q  <= '0;
      frame_q    <= '0;
      ds         <= 1'b0;
      shcp       <= 1'b0;
      stcp       <= 1'b0;
      oe         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      stcp       <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          ds   <= 1'b0;
          shcp <= 1'b0;
          if (shift_en) state_q <= StLoad;
        end
        StLoad: begin
          frame_q   <= {sel, seg};
          cnt_clk_q <= '0;
          cnt_bit_q <= '0;
          ds        <= seg[0];
          shcp      <= 1'b0;
          state_q   <= StShift;
        end
        StShift: begin
          if (cnt_clk_q == ClkLast) begin
            cnt_clk_q <= '0;
            shcp      <= 1'b0;
            if (cnt_bit_q == BitLast) begin
              state_q    <= StLatch;
              ds         <= 1'b0;
              stcp       <= 1'b1;
              frame_done <= 1'b1;
              oe         <= 1'b0;
            end else begin
              cnt_bit_q <= bit_inc;
              ds        <= slot_bit(frame_q, bit_inc);
            end
          end else begin
            cnt_clk_q <= clk_inc;
            ds        <= slot_bit(frame_q, cnt_bit_q);
            shcp      <= (clk_inc >= ClkHalf);
          end
        end
        StLatch: begin
          ds      <= 1'b0;
          shcp    <= 1'b0;
          state_q <= shift_en ? StLoad : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_ctrl.sv
// Bench for hc595_ctrl: a slot-position model checks every output cycle, and directed
// frames pin bit order, latch timing, shift_en handling, async reset and a CNT_DIV=2 build.
module tb_hc595_ctrl;

  localparam int D       = 4;
  localparam int FB      = 14;
  localparam int LastPos = FB * D + 1;  // position of LATCH within a frame (LOAD = 0)
  localparam logic [13:0] SeqC0 = 14'b10000011000000;
  localparam logic [13:0] SeqF9 = 14'b00000111111001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       shift_en;
  logic       shift_en2;
  logic       ds, shcp, stcp, oe, frame_done;
  logic       ds2, shcp2, stcp2, oe2, frame_done2;

  always #5 clk = ~clk;

  hc595_ctrl #(.CNT_DIV(D), .FRAME_BITS(FB)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .sel(sel), .seg(seg), .shift_en(shift_en),
    .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe), .frame_done(frame_done)
  );

  hc595_ctrl #(.CNT_DIV(2), .FRAME_BITS(FB)) u_dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .sel(sel), .seg(seg), .shift_en(shift_en2),
    .ds(ds2), .shcp(shcp2), .stcp(stcp2), .oe(oe2), .frame_done(frame_done2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Model: transmit order as a plain array, frame progress as a position counter.
  function automatic logic [13:0] order(input logic [5:0] s, input logic [7:0] g);
    logic [13:0] r;
    for (int i = 0; i < 8; i++) r[i] = g[i];
    for (int j = 0; j < 6; j++) r[8+j] = s[5-j];
    return r;
  endfunction

  bit          busy;
  int          pos;
  logic [13:0] seq;
  logic        oe_m;
  bit          chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0; pos = 0; oe_m = 1'b1; seq = '0;
    end else if (!busy) begin
      if (shift_en) begin busy = 1'b1; pos = 0; end
    end else if (pos == 0) begin
      seq = order(sel, seg); pos = 1;
    end else if (pos < LastPos) begin
      pos++;
      if (pos == LastPos) oe_m = 1'b0;
    end else if (shift_en) begin
      pos = 0;
    end else begin
      busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (chk_en) begin
      e = {3'b000, oe_m, 1'b0};
      if (busy && pos >= 1 && pos < LastPos) begin
        e[4] = seq[(pos-1)/D];
        e[3] = (((pos-1) % D) >= D/2);
      end else if (busy && pos == LastPos) begin
        e[2] = 1'b1;
        e[0] = 1'b1;
      end
      chk("cycle_cmp", 32'({ds, shcp, stcp, oe, frame_done}), 32'(e));
    end
  end

  // CNT_DIV=2 instance: record first frame bits, shcp pattern and latch times.
  int          n2, p1, p2, pat_bad;
  logic [13:0] b2;
  always @(negedge clk) begin
    if (!rst_n) begin
      n2 = 0; p1 = 0; p2 = 0; pat_bad = 0; b2 = '0;
    end else begin
      n2++;
      if (stcp2) begin
        if (p1 == 0) p1 = n2;
        else if (p2 == 0) p2 = n2;
      end
      if (n2 >= 2 && n2 <= 29) begin
        if ((n2-2) % 2 == 0) b2[(n2-2)/2] = ds2;
        if (shcp2 !== (((n2-2) % 2) == 1)) pat_bad++;
      end
    end
  end

  // Called right after reset release; walks the first frame cycle by cycle.
  task automatic first_frame(input string tag);
    logic [13:0] b;
    int          edges, bad, first, k, ph;
    logic        prev, oe_pre;
    b = '0; edges = 0; bad = 0; first = 0; prev = 1'b0; oe_pre = 1'b0;
    for (int n = 1; n <= LastPos + 1; n++) begin
      @(negedge clk);
      if (n >= 2 && n <= LastPos) begin
        k  = (n-2) / D;
        ph = (n-2) % D;
        if (ph == 1) b[k] = ds;
        if (shcp && !prev) begin
          edges++;
          if (ph != D/2) bad++;
        end
      end else if (shcp && !prev) begin
        bad++;
      end
      prev = shcp;
      if (stcp && first == 0) first = n;
      if (n == LastPos) oe_pre = oe;
    end
    chk({tag, "_ds_seq"}, 32'(b), 32'(SeqC0));
    chk({tag, "_shcp_edges"}, 32'(edges), 32'd14);
    chk({tag, "_shcp_misplaced"}, 32'(bad), 32'd0);
    chk({tag, "_first_stcp_cycle"}, 32'(first), 32'd58);
    chk({tag, "_oe_before_latch"}, 32'(oe_pre), 32'd1);
    chk({tag, "_oe_at_latch"}, 32'(oe), 32'd0);
  endtask

  // Called on the LATCH output cycle with shift_en=1; captures the next frame's slots.
  task automatic grab(input int act, output logic [13:0] b, output logic st);
    b = '0;
    @(negedge clk);
    for (int k = 0; k < FB; k++) begin
      for (int c = 0; c < D; c++) begin
        @(negedge clk);
        if (c == 1) b[k] = ds;
        if (act == 1 && k == 3 && c == 0) begin sel = 6'b100000; seg = 8'hF9; end
        if (act == 2 && k == 5 && c == 0) shift_en = 1'b0;
      end
    end
    @(negedge clk);
    st = stcp;
  endtask

  initial begin
    logic [13:0] b;
    logic        st;
    int          cnt, badint;
    rst_n = 1'b0; sel = 6'b000001; seg = 8'hC0; shift_en = 1'b1; shift_en2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outputs", 32'({ds, shcp, stcp, oe, frame_done}), 32'(5'b00010));
    chk("reset_outputs_div2", 32'({ds2, shcp2, stcp2, oe2, frame_done2}), 32'(5'b00010));
    #1 rst_n = 1'b1;
    first_frame("f1");

    cnt = 0; badint = 0;
    for (int m = 1; m <= 10 * (LastPos + 1); m++) begin
      @(negedge clk);
      if (stcp) begin
        cnt++;
        if (m != cnt * (LastPos + 1)) badint++;
      end
    end
    chk("ten_frames_pulses", 32'(cnt), 32'd10);
    chk("ten_frames_period", 32'(badint), 32'd0);

    chk("div2_first_stcp", 32'(p1), 32'd30);
    chk("div2_second_stcp", 32'(p2), 32'd60);
    chk("div2_ds_seq", 32'(b2), 32'(SeqC0));
    chk("div2_shcp_pattern", 32'(pat_bad), 32'd0);

    grab(1, b, st);
    chk("midchange_old_frame", 32'(b), 32'(SeqC0));
    chk("midchange_old_stcp", 32'(st), 32'd1);
    grab(0, b, st);
    chk("midchange_new_frame", 32'(b), 32'(SeqF9));
    chk("midchange_new_stcp", 32'(st), 32'd1);

    grab(2, b, st);
    chk("drop_en_frame", 32'(b), 32'(SeqF9));
    chk("drop_en_stcp", 32'(st), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({ds, shcp, stcp, oe, frame_done}), 32'd0);
    end
    shift_en = 1'b1;
    grab(0, b, st);
    chk("reraise_frame", 32'(b), 32'(SeqF9));
    chk("reraise_stcp", 32'(st), 32'd1);

    @(negedge clk);
    repeat (9 * D + 1) @(negedge clk);
    chk("pre_reset_oe", 32'(oe), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({ds, shcp, stcp, oe, frame_done}), 32'(5'b00010));
    sel = 6'b000001; seg = 8'hC0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    first_frame("f2");

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected done earlier");
    $fatal(1, "watchdog");
  end

endmodule
